// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 key entry controller.
// Optional typematic-repeat filter in the top is enabled by KEY_REPEAT_FILTER_EN.
package ps2_key_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BRK  = 3'd1,
        EXT  = 3'd2,
        DEC  = 3'd3,
        WAIT = 3'd4
    } state_t;

    localparam logic [7:0] BREAK_CODE_DEF = 8'hF0;
    localparam logic [7:0] EXT_CODE_DEF   = 8'hE0;

    // Bit positions within the decoder's one-hot flag vector
    localparam int NUMBER_F = 0;
    localparam int ENTER_F  = 1;
    localparam int MANAGE_F = 2;

    localparam logic [4:0] CMD_N = 5'h10;
    localparam logic [4:0] CMD_R = 5'h11;

endpackage

// File: rtl/ps2_key_entry_ctrl_hex_accumulator.sv
// Hex operand accumulator: shifts in digits, clears, reloads a saved operand; 1-cycle update.
// No backpressure; a digit beyond DIGITS and any externally reported drop set the sticky ovf.
module hex_accumulator
    import ps2_key_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int W      = 4 * DIGITS,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_shift,
    input  logic [3:0]    i_digit,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [W-1:0]  i_load_val,
    input  logic          i_commit,
    input  logic          i_drop,
    output logic [W-1:0]  o_value,
    output logic [CW-1:0] o_cnt,
    output logic          o_ovf
);

    localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

    logic [W-1:0]  r_value;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          w_full;

    assign w_full = (r_cnt >= MAX_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (i_clear) begin
                r_value <= '0;
                r_cnt   <= '0;
            end else if (i_load) begin
                r_value <= i_load_val;
                r_cnt   <= MAX_CNT;
            end else if (i_commit) begin
                r_value <= '0;
                r_cnt   <= '0;
            end else if (i_shift && !w_full) begin
                r_value <= {r_value[W-5:0], i_digit};
                r_cnt   <= r_cnt + CW'(1);
            end
            // A drop in the same cycle as a clear still leaves ovf set: the loss is newer
            r_ovf <= (r_ovf & ~i_clear) | i_drop | (i_shift & w_full);
        end
    end

    assign o_value = r_value;
    assign o_cnt   = r_cnt;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/ps2_key_entry_ctrl.sv
// PS/2 byte sequencer feeding an external keycode decoder and a hex operand builder; scan->value 2 cycles.
// Commit port is valid/ready; bytes arriving while decoding or awaiting ready are dropped and flag ovf. Macro: KEY_REPEAT_FILTER_EN.
module ps2_key_entry_ctrl
    import ps2_key_pkg::*;
#(
    parameter  int         DIGITS     = 4,
    parameter  logic [7:0] BREAK_CODE = BREAK_CODE_DEF,
    parameter  logic [7:0] EXT_CODE   = EXT_CODE_DEF,
    localparam int         W          = 4 * DIGITS,
    localparam int         CW         = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scan_valid,
    input  logic [7:0]    scan_code,
    output logic [7:0]    key_code,
    input  logic [4:0]    dec_out,
    input  logic [2:0]    dec_flags,
    output logic [W-1:0]  value,
    output logic [CW-1:0] digit_cnt,
    output logic          commit_valid,
    output logic [W-1:0]  commit_data,
    input  logic          commit_ready,
    output logic          ovf
);

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_key_code;
    logic          r_commit_valid;
    logic [W-1:0]  r_commit_data;
    logic [W-1:0]  r_last_commit;

    logic [W-1:0]  w_value;
    logic [CW-1:0] w_cnt;
    logic          w_ovf;

    logic          w_is_brk;
    logic          w_is_ext;
    logic          w_repeat;
    logic          w_latch;
    logic          w_shift;
    logic          w_commit;
    logic          w_clear;
    logic          w_load;
    logic          w_drop;

    assign w_is_brk = (scan_code == BREAK_CODE);
    assign w_is_ext = (scan_code == EXT_CODE);

`ifdef KEY_REPEAT_FILTER_EN
    logic [7:0] r_held;
    logic       r_held_vld;

    assign w_repeat = r_held_vld && (scan_code == r_held);

    // Only the break of the held key forgets it; other breaks leave the filter armed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held     <= '0;
            r_held_vld <= 1'b0;
        end else if (w_latch) begin
            r_held     <= scan_code;
            r_held_vld <= 1'b1;
        end else if ((r_state == BRK) && scan_valid && w_repeat) begin
            r_held_vld <= 1'b0;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (scan_valid) begin
                    if (w_is_brk)      w_next = BRK;
                    else if (w_is_ext) w_next = EXT;
                    else if (!w_repeat) w_next = DEC;
                end
            end
            BRK: begin
                if (scan_valid) w_next = IDLE;
            end
            EXT: begin
                if (scan_valid) w_next = w_is_brk ? BRK : IDLE;
            end
            DEC: begin
                w_next = w_commit ? WAIT : IDLE;
            end
            WAIT: begin
                if (commit_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Decoder outputs are combinational on key_code, so they are only meaningful in DEC
    always_comb begin
        w_latch  = 1'b0;
        w_shift  = 1'b0;
        w_commit = 1'b0;
        w_clear  = 1'b0;
        w_load   = 1'b0;
        w_drop   = 1'b0;
        case (r_state)
            IDLE: begin
                w_latch = scan_valid && !w_is_brk && !w_is_ext && !w_repeat;
            end
            DEC: begin
                w_drop = scan_valid;
                if (dec_flags[NUMBER_F]) begin
                    w_shift = 1'b1;
                end else if (dec_flags[ENTER_F]) begin
                    w_commit = (w_cnt != '0);
                end else if (dec_flags[MANAGE_F]) begin
                    w_clear = (dec_out == CMD_N);
                    w_load  = (dec_out == CMD_R);
                end
            end
            WAIT: begin
                w_drop = scan_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_code     <= '0;
            r_commit_valid <= 1'b0;
            r_commit_data  <= '0;
            r_last_commit  <= '0;
        end else begin
            if (w_latch) r_key_code <= scan_code;
            if (w_commit) begin
                r_commit_valid <= 1'b1;
                r_commit_data  <= w_value;
                r_last_commit  <= w_value;
            end else if ((r_state == WAIT) && commit_ready) begin
                r_commit_valid <= 1'b0;
            end
        end
    end

    hex_accumulator #(
        .DIGITS (DIGITS)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .i_shift    (w_shift),
        .i_digit    (dec_out[3:0]),
        .i_clear    (w_clear),
        .i_load     (w_load),
        .i_load_val (r_last_commit),
        .i_commit   (w_commit),
        .i_drop     (w_drop),
        .o_value    (w_value),
        .o_cnt      (w_cnt),
        .o_ovf      (w_ovf)
    );

    assign key_code     = r_key_code;
    assign value        = w_value;
    assign digit_cnt    = w_cnt;
    assign commit_valid = r_commit_valid;
    assign commit_data  = r_commit_data;
    assign ovf          = w_ovf;

endmodule

// File: tb/tb_ps2_key_entry_ctrl.sv
// Bench for ps2_key_entry_ctrl: set-2 keycode decoder on key_code, byte-rule reference model,
// directed key sequences with literal expectations, then randomized bytes and ready.
module tb_ps2_key_entry_ctrl;

`ifdef KEY_REPEAT_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic [7:0]  key_code;
    logic [4:0]  dec_out;
    logic [2:0]  dec_flags;
    logic [15:0] value;
    logic [2:0]  digit_cnt;
    logic        commit_valid;
    logic [15:0] commit_data;
    logic        commit_ready;
    logic        ovf;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] xq[$];

    always #5 clk = ~clk;

    ps2_key_entry_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .scan_valid   (scan_valid),
        .scan_code    (scan_code),
        .key_code     (key_code),
        .dec_out      (dec_out),
        .dec_flags    (dec_flags),
        .value        (value),
        .digit_cnt    (digit_cnt),
        .commit_valid (commit_valid),
        .commit_data  (commit_data),
        .commit_ready (commit_ready),
        .ovf          (ovf)
    );

    // Keycode decoder: returns {MANAGE, ENTER, NUMBER, out[4:0]}
    function automatic logic [7:0] dec_lookup(input logic [7:0] b);
        case (b)
            8'h45: return {3'b001, 5'h0};
            8'h16: return {3'b001, 5'h1};
            8'h1E: return {3'b001, 5'h2};
            8'h26: return {3'b001, 5'h3};
            8'h25: return {3'b001, 5'h4};
            8'h2E: return {3'b001, 5'h5};
            8'h36: return {3'b001, 5'h6};
            8'h3D: return {3'b001, 5'h7};
            8'h3E: return {3'b001, 5'h8};
            8'h46: return {3'b001, 5'h9};
            8'h1C: return {3'b001, 5'hA};
            8'h32: return {3'b001, 5'hB};
            8'h21: return {3'b001, 5'hC};
            8'h23: return {3'b001, 5'hD};
            8'h24: return {3'b001, 5'hE};
            8'h2B: return {3'b001, 5'hF};
            8'h5A: return {3'b010, 5'h00};
            8'h31: return {3'b100, 5'h10};
            8'h2D: return {3'b100, 5'h11};
            default: return 8'h00;
        endcase
    endfunction

    always_comb {dec_flags, dec_out} = dec_lookup(key_code);

    typedef struct {
        bit          skip;
        bit          ext;
        bit          pend;
        bit          waiting;
        logic [7:0]  key;
        logic [15:0] value;
        int          cnt;
        bit          ovf;
        bit          cvalid;
        logic [15:0] cdata;
        logic [15:0] last;
        logic [7:0]  held;
        bit          held_v;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.skip = 0; r.ext = 0; r.pend = 0; r.waiting = 0; r.key = 0;
        r.value = 0; r.cnt = 0; r.ovf = 0; r.cvalid = 0; r.cdata = 0;
        r.last = 0; r.held = 0; r.held_v = 0;
        return r;
    endfunction

    // One clock of the entry rules, applied to the byte stream and ready
    function automatic mdl_t mdl_step(mdl_t s, logic sv, logic [7:0] sc, logic rdy);
        mdl_t n;
        logic [7:0] d;
        n = s;
        if (s.pend) begin
            d = dec_lookup(s.key);
            n.pend = 0;
            if (d[5]) begin
                if (s.cnt < 4) begin
                    n.value = 16'((s.value * 16) + d[3:0]);
                    n.cnt   = s.cnt + 1;
                end else n.ovf = 1;
            end else if (d[6]) begin
                if (s.cnt > 0) begin
                    n.cdata = s.value; n.last = s.value; n.cvalid = 1;
                    n.value = 0; n.cnt = 0; n.waiting = 1;
                end
            end else if (d[7]) begin
                if (d[4:0] == 5'h10) begin
                    n.value = 0; n.cnt = 0; n.ovf = 0;
                end else if (d[4:0] == 5'h11) begin
                    n.value = s.last; n.cnt = 4;
                end
            end
            if (sv) n.ovf = 1;
        end else if (s.waiting) begin
            if (sv) n.ovf = 1;
            if (rdy) begin
                n.cvalid = 0; n.waiting = 0;
            end
        end else if (sv) begin
            if (s.skip) begin
                n.skip = 0;
                if (FILTER && s.held_v && sc == s.held) n.held_v = 0;
            end else if (s.ext) begin
                n.ext = 0;
                if (sc == 8'hF0) n.skip = 1;
            end else if (sc == 8'hF0) begin
                n.skip = 1;
            end else if (sc == 8'hE0) begin
                n.ext = 1;
            end else if (!(FILTER && s.held_v && sc == s.held)) begin
                n.key = sc; n.pend = 1; n.held = sc; n.held_v = 1;
            end
        end
        return n;
    endfunction

    mdl_t m;
    always @(posedge clk or posedge rst) begin
        if (rst) m <= mdl_reset();
        else     m <= mdl_step(m, scan_valid, scan_code, commit_ready);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("key_code",     32'(key_code),     32'(m.key));
        check("value",        32'(value),        32'(m.value));
        check("digit_cnt",    32'(digit_cnt),    32'(m.cnt));
        check("ovf",          32'(ovf),          32'(m.ovf));
        check("commit_valid", 32'(commit_valid), 32'(m.cvalid));
        check("commit_data",  32'(commit_data),  32'(m.cdata));
        if (!rst && commit_valid && commit_ready) xq.push_back(commit_data);
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        scan_valid = 1'b1;
        scan_code  = b;
        @(posedge clk); #1;
        scan_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] b);
        send(b);
        send(8'hF0);
        send(b);
    endtask

    task automatic expect_acc(input string tag, input logic [15:0] v, input int c, input logic o);
        @(negedge clk);
        check({tag, ".value"}, 32'(value), 32'(v));
        check({tag, ".cnt"},   32'(digit_cnt), 32'(c));
        check({tag, ".ovf"},   32'(ovf), 32'(o));
    endtask

    localparam int NPOOL = 24;
    logic [7:0] pool [NPOOL] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                                 8'h5A, 8'h5A, 8'h31, 8'h2D, 8'hF0, 8'hF0, 8'hE0, 8'h29};

    initial begin
        rst = 1'b1; scan_valid = 1'b0; scan_code = 8'h00; commit_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.key_code", 32'(key_code), 32'h0);
        check("rst.commit_valid", 32'(commit_valid), 32'h0);
        check("rst.commit_data", 32'(commit_data), 32'h0);
        #1 rst = 1'b0;
        expect_acc("rst", 16'h0, 0, 1'b0);

        // Simple commit with breaks interleaved
        xq.delete();
        press(8'h16); press(8'h1C); press(8'h5A);
        @(negedge clk);
        check("t1.xfers", 32'(xq.size()), 32'd1);
        if (xq.size() > 0) check("t1.data", 32'(xq[0]), 32'h001A);
        expect_acc("t1", 16'h0, 0, 1'b0);

        // Digit overflow then N
        press(8'h16); press(8'h1E); press(8'h26); press(8'h25); press(8'h2E);
        expect_acc("t2", 16'h1234, 4, 1'b1);
        press(8'h31);
        expect_acc("t2n", 16'h0, 0, 1'b0);

        // Held commit, byte dropped while waiting
        commit_ready = 1'b0;
        xq.delete();
        press(8'h1C); press(8'h32);
        send(8'h5A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3.valid", 32'(commit_valid), 32'd1);
            check("t3.data", 32'(commit_data), 32'h00AB);
        end
        send(8'h16);
        expect_acc("t3drop", 16'h0, 0, 1'b1);
        check("t3.valid_held", 32'(commit_valid), 32'd1);
        @(posedge clk); #1 commit_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t3.xfers", 32'(xq.size()), 32'd1);
        if (xq.size() > 0) check("t3.xdata", 32'(xq[0]), 32'h00AB);
        check("t3.valid_low", 32'(commit_valid), 32'd0);
        send(8'hF0); send(8'h5A);

        // Recall last commit
        xq.delete();
        press(8'h31); press(8'h2D);
        expect_acc("t4", 16'h00AB, 4, 1'b0);
        press(8'h5A);
        @(negedge clk);
        check("t4.xfers", 32'(xq.size()), 32'd1);
        if (xq.size() > 0) check("t4.data", 32'(xq[0]), 32'h00AB);

        // Extended sequences ignored; Enter with nothing held ignored
        xq.delete();
        send(8'hE0); send(8'h5A);
        send(8'hE0); send(8'hF0); send(8'h5A);
        expect_acc("t5", 16'h0, 0, 1'b0);
        send(8'h5A);
        @(negedge clk);
        check("t5.valid", 32'(commit_valid), 32'd0);
        check("t5.xfers", 32'(xq.size()), 32'd0);
        send(8'hF0); send(8'h5A);

        // Async reset aborts a pending commit
        commit_ready = 1'b0;
        xq.delete();
        press(8'h16);
        send(8'h5A);
        @(negedge clk);
        check("t6.valid_pre", 32'(commit_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6.valid_rst", 32'(commit_valid), 32'd0);
        check("t6.value_rst", 32'(value), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        commit_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t6.xfers", 32'(xq.size()), 32'd0);

        // Typematic repeat
        send(8'h16); send(8'h16); send(8'h16);
        if (FILTER) expect_acc("t7", 16'h0001, 1, 1'b0);
        else        expect_acc("t7", 16'h0111, 3, 1'b0);
        send(8'hF0); send(8'h16);
        press(8'h31);

        // Randomized bytes and ready, checked every cycle against the model
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            scan_valid   = ($urandom_range(0, 2) == 0);
            scan_code    = pool[$urandom_range(0, NPOOL - 1)];
            commit_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1 scan_valid = 1'b0; commit_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
